// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out word assembler: collects framed serial bits into WIDTH-bit words
// and presents each completed word on a registered valid/ready output.
`timescale 1ns/1ps
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             sync_err
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sh, w_sh_nxt, w_shifted, w_first;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_complete, w_sync_set, w_accept, w_drop;

  // w_shifted is the register with this bit appended; w_first starts a fresh word.
  always_comb begin
    if (MSB_FIRST) begin
      w_shifted = {r_sh[WIDTH-2:0], bit_in};
      w_first   = {{(WIDTH-1){1'b0}}, bit_in};
    end else begin
      w_shifted = {bit_in, r_sh[WIDTH-1:1]};
      w_first   = {bit_in, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    w_complete  = 1'b0;
    w_sync_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bit_valid && frame_start) begin
          w_sh_nxt    = w_first;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (frame_start) begin
            w_sync_set = 1'b1;
            w_sh_nxt   = w_first;
            w_cnt_nxt  = CW'(1);
          end else if (r_cnt == LAST) begin
            w_complete  = 1'b1;
            w_sh_nxt    = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_sh_nxt  = w_shifted;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A finished word replaces the held one only if the slot is free or being consumed now.
  assign w_accept = w_complete && (!dout_valid || dout_ready);
  assign w_drop   = w_complete && dout_valid && !dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sh       <= '0;
      r_cnt      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_cnt   <= w_cnt_nxt;
      busy    <= (w_state_nxt == SHIFT);

      if (w_accept) begin
        dout       <= w_shifted;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end

      if (w_drop)          overrun <= 1'b1;
      else if (clr_flags)  overrun <= 1'b0;

      if (w_sync_set)      sync_err <= 1'b1;
      else if (clr_flags)  sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized scoreboard bench for sipo_deserializer; MSB-first and LSB-first instances share
// one stimulus stream and are checked against a bit-list reference model.
`timescale 1ns/1ps
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in, bit_valid, frame_start, clr_flags, dout_ready;
  logic [7:0] dout_m, dout_l;
  logic       dv_m, dv_l, busy_m, busy_l, ovr_m, ovr_l, serr_m, serr_l;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
    .clr_flags(clr_flags), .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
    .busy(busy_m), .overrun(ovr_m), .sync_err(serr_m));

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
    .clr_flags(clr_flags), .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
    .busy(busy_l), .overrun(ovr_l), .sync_err(serr_l));

  typedef struct packed {logic [7:0] m; logic [7:0] l;} exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: framing state as a list of collected bits plus output-slot occupancy.
  bit   m_bits[$];
  bit   m_in, m_valid, m_ovr, m_serr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_bits.delete();
    q.delete();
    m_in = 0; m_valid = 0; m_ovr = 0; m_serr = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then check flags after the edge.
  task automatic step(input bit bv, input bit fs, input bit b, input bit rdy, input bit clr);
    bit          done = 0, ovr_set = 0, serr_set = 0;
    int unsigned wm = 0, wl = 0;
    bit_valid = bv; frame_start = fs; bit_in = b; dout_ready = rdy; clr_flags = clr;
    if (bv) begin
      if (fs) begin
        if (m_in) serr_set = 1;
        m_bits.delete();
        m_bits.push_back(b);
        m_in = 1;
      end else if (m_in) begin
        m_bits.push_back(b);
        if (m_bits.size() == 8) begin
          done = 1;
          m_in = 0;
          foreach (m_bits[i]) begin
            wm = wm * 2 + int'(m_bits[i]);
            wl = wl + (int'(m_bits[i]) << i);
          end
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        q.push_back('{m: 8'(wm), l: 8'(wl)});
        m_valid = 1;
      end else begin
        ovr_set = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    m_ovr  = ovr_set  ? 1'b1 : (clr ? 1'b0 : m_ovr);
    m_serr = serr_set ? 1'b1 : (clr ? 1'b0 : m_serr);
    @(posedge clk); #1;
    chk("busy",       {busy_m, busy_l}, {m_in, m_in});
    chk("dout_valid", {dv_m, dv_l},     {m_valid, m_valid});
    chk("overrun",    {ovr_m, ovr_l},   {m_ovr, m_ovr});
    chk("sync_err",   {serr_m, serr_l}, {m_serr, m_serr});
  endtask

  task automatic send_word(input logic [7:0] w, input int gap, input bit rdy);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, w[7-i], rdy, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'($urandom), rdy, 1'b0);
    end
  endtask

  // Monitor: a presented word must match the scoreboard head and hold until consumed.
  always @(negedge clk) begin
    if (!rst && (dv_m || dv_l)) begin
      if (q.size() == 0) begin
        chk("dout_valid_unexpected", {dv_m, dv_l}, 2'b00);
      end else begin
        chk("dout_msb", dout_m, q[0].m);
        chk("dout_lsb", dout_l, q[0].l);
        if (dout_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; bit_in = 0; bit_valid = 0; frame_start = 0; clr_flags = 0; dout_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout",  {dout_m, dout_l}, 16'h0);
    chk("reset_flags", {dv_m, dv_l, busy_m, busy_l, ovr_m, ovr_l, serr_m, serr_l}, 8'h0);
    rst = 1'b0;

    // Basic word, then same word with strobe gaps and toggling idle data
    send_word(8'hC0, 0, 1'b1);
    step(0, 0, 0, 1, 0);
    chk("t1_dout_msb", dout_m, 8'hC0);
    chk("t2_dout_lsb", dout_l, 8'h03);
    step(0, 0, 0, 1, 0);
    send_word(8'hC0, 2, 1'b1);
    step(0, 0, 0, 1, 0);

    // Consumer stalled: second word dropped, then drained and flag cleared
    send_word(8'hC0, 0, 1'b0);
    send_word(8'h5A, 0, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("t4_hold_dout", dout_m, 8'hC0);
    chk("t4_overrun",   ovr_m, 1'b1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    chk("t4_cleared", ovr_m, 1'b0);

    // Resync mid-word, then stray unframed bits in IDLE
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1'($urandom), 1, 0);
    send_word(8'h81, 0, 1'b1);
    step(0, 0, 0, 1, 0);
    chk("t5_sync_err", serr_m, 1'b1);
    chk("t5_dout",     dout_m, 8'h81);
    for (int i = 0; i < 6; i++) step(1, 0, 1'($urandom), 1, 0);
    step(0, 0, 0, 1, 1);

    // Async reset mid-word with a pending word and overrun flagged
    send_word(8'hA5, 0, 1'b0);
    send_word(8'h3C, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1, i == 0, 1'($urandom), 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_dout",  {dout_m, dout_l}, 16'h0);
    chk("t6_async_flags", {dv_m, dv_l, busy_m, busy_l, ovr_m, ovr_l, serr_m, serr_l}, 8'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 0, 1'($urandom), 1, 0);
    send_word(8'h6B, 0, 1'b1);
    step(0, 0, 0, 1, 0);
    chk("t6_after_reset", dout_m, 8'h6B);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit fs = m_in ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 9) < 7, fs, 1'($urandom), $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
